// File: rtl/pc_fetch.sv
// Instruction-fetch stage: program counter, PC hi-tmp and instruction register.
// Two-phase FETCH/EXEC sequencer driving the control decoder.
module pc_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rom_data,
  input  logic [7:0]  data_bus,
  input  logic        _pchitmp_in,
  input  logic        _pclo_in,
  input  logic        _pc_in,
  input  logic        stall,
  output logic [15:0] pc_addr,
  output logic [7:0]  ir_hi,
  output logic [7:0]  ir_lo,
  output logic        phase_exec,
  output logic [7:0]  pchitmp
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  pchitmp_q, pchitmp_d;
  logic [7:0]  ir_hi_q, ir_hi_d;
  logic [7:0]  ir_lo_q, ir_lo_d;

  logic        do_exec;
  logic        ld_pc;
  logic        ld_lo;

  // Strobes only qualify in an unstalled EXEC, so X in FETCH is masked.
  always_comb begin
    do_exec = (state_q == EXEC) && !stall;
    ld_pc   = do_exec && !_pc_in;
    ld_lo   = do_exec && _pc_in && !_pclo_in;
  end

  // Next-state, PC update priority and IR/hi-tmp loads.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pchitmp_d = pchitmp_q;
    ir_hi_d   = ir_hi_q;
    ir_lo_d   = ir_lo_q;
    unique case (state_q)
      FETCH: begin
        ir_hi_d = rom_data[15:8];
        ir_lo_d = rom_data[7:0];
        state_d = EXEC;
      end
      EXEC: begin
        if (do_exec) begin
          state_d = FETCH;
          if (!_pchitmp_in) pchitmp_d = data_bus;
          unique case (1'b1)
            ld_pc:   pc_d = {pchitmp_q, data_bus};
            ld_lo:   pc_d = {pc_q[15:8], data_bus};
            default: pc_d = pc_q + 16'd1;
          endcase
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      pchitmp_q <= 8'h00;
      ir_hi_q   <= 8'h00;
      ir_lo_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pchitmp_q <= pchitmp_d;
      ir_hi_q   <= ir_hi_d;
      ir_lo_q   <= ir_lo_d;
    end
  end

  // Outputs are direct views of registered state.
  always_comb begin
    pc_addr    = pc_q;
    ir_hi      = ir_hi_q;
    ir_lo      = ir_lo_q;
    phase_exec = (state_q == EXEC);
    pchitmp    = pchitmp_q;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Owns the 16-bit program counter, the PC high-byte holding register, and the instruction register.
- Presents the latched ROM high byte to the decoder's `hi_rom` input and the low byte as the immediate.
- Consumes the decoder's active-low `_pchitmp_in`, `_pclo_in` and `_pc_in` strobes to execute jumps; otherwise sequences linearly through ROM with a two-phase FETCH/EXEC machine.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_data  input  16  ROM word at pc_addr; [15:8] = hi byte (opcode/device), [7:0] = lo byte (immediate).
- data_bus  input  8  main data bus value driven during EXEC.
- _pchitmp_in  input  1  active-low: load PC hi-tmp from data_bus.
- _pclo_in  input  1  active-low: load PC low byte from data_bus.
- _pc_in  input  1  active-low: load full PC = {pchitmp, data_bus}; already flag-qualified upstream.
- stall  input  1  active-high: hold in EXEC, for slow devices such as the UART.
- pc_addr  output  16  ROM address = current PC.
- ir_hi  output  8  latched instruction hi byte, to control hi_rom.
- ir_lo  output  8  latched immediate byte.
- phase_exec  output  1  high in EXEC; decoder strobes are honoured only when high.
- pchitmp  output  8  current hi-tmp register, for debug/observation.

Behaviour:
- Reset is synchronous and active-high; clock is `clk`, reset is `reset`.
- On a clock edge with reset=1:
  - PC = RESET_VECTOR, pchitmp = 8'h00, ir_hi = ir_lo = 8'h00.
  - State = FETCH, phase_exec = 0.
  - Reset overrides every other input, including mid-EXEC and during stall.
- States: FETCH and EXEC.
- FETCH (one cycle):
  - At the edge, ir_hi <= rom_data[15:8], ir_lo <= rom_data[7:0], and state goes to EXEC.
  - PC and pchitmp are unchanged.
  - Strobes are ignored in FETCH.
- EXEC with stall=1:
  - Remain in EXEC.
  - PC, IR and pchitmp hold; strobes are not applied.
- EXEC with stall=0, at the edge:
  - Apply the PC update below.
  - If _pchitmp_in=0, pchitmp <= data_bus.
  - State goes to FETCH.
- PC update priority (highest first):
  1. _pc_in=0 -> PC <= {pchitmp_old, data_bus}, where pchitmp_old is the pre-edge value, even if _pchitmp_in is also low this cycle.
  2. _pclo_in=0 -> PC[7:0] <= data_bus; PC[15:8] unchanged.
  3. Otherwise PC <= PC + 1, modulo 2^16: 16'hFFFF wraps to 16'h0000.
- A jump or low-byte load suppresses the increment.
- Outputs are registered state; pc_addr mirrors PC combinationally.
- Latency:
  - One instruction takes 2 cycles without stall, and 2+N cycles with N stall cycles.
  - The new PC is visible on pc_addr the cycle after EXEC completes; it is fetched in the following FETCH.
- The IR is stable throughout EXEC, so decoder outputs are glitch-free for the whole EXEC phase.
- X on strobe inputs during FETCH must not affect state.

Test Plan:
1. Sequential fetch: reset, RESET_VECTOR=0, ROM[n]=16'h1100+n, no strobes.
   - pc_addr must step 0,0,1,1,2,2 (FETCH/EXEC pairs).
   - ir_lo must read 00,01,02 in successive EXECs.
2. Far jump:
   - EXEC with _pchitmp_in=0 and data_bus=8'h12 -> pchitmp=8'h12, PC increments.
   - Next EXEC with _pc_in=0 and data_bus=8'h34 -> pc_addr=16'h1234 after the edge.
3. Low-byte load: PC=16'h0A05, EXEC with _pclo_in=0 and data_bus=8'hF0 -> PC=16'h0AF0, no increment.
4. Simultaneous strobes:
   - pchitmp=8'h01; EXEC with _pchitmp_in=0, _pc_in=0, _pclo_in=0, data_bus=8'h77.
   - Required: PC=16'h0177 and pchitmp=8'h77.
5. Wrap and stall:
   - PC=16'hFFFF, stall=1 for 3 cycles -> phase_exec stays 1, PC holds.
   - Release stall -> PC=16'h0000.
6. Reset mid-EXEC with stall=1 and _pc_in=0 -> next cycle PC=RESET_VECTOR, pchitmp=0, IR=0, phase_exec=0.
